scr1_dmem_mbox: RTL and testbench
=================================

SCR1_DMEM_MBOX -- requirements
Module: scr1_dmem_mbox

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries, power of two, range 2..64.
REQ-002 SHALL have port clk  input  1  core clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port dmem_req_ack  output  1  request accepted.
REQ-005 SHALL have port dmem_req  input  1  request valid.
REQ-006 SHALL have port dmem_cmd  input  1  SCR1_MEM_CMD_RD / SCR1_MEM_CMD_WR.
REQ-007 SHALL have port dmem_width  input  2  SCR1_MEM_WIDTH_BYTE/HWORD/WORD.
REQ-008 SHALL have port dmem_addr  input  SCR1_DMEM_AWIDTH  byte address; only bits [3:0] decoded.
REQ-009 SHALL have port dmem_wdata  input  SCR1_DMEM_DWIDTH  write data, valid with the request.
REQ-010 SHALL have port dmem_rdata  output  SCR1_DMEM_DWIDTH  read data, valid with the response.
REQ-011 SHALL have port dmem_resp  output  2  SCR1_MEM_RESP_NOTRDY / RDY_OK / RDY_ER.
REQ-012 SHALL have port mbox_vld  output  1  FIFO head valid; equals "not empty".
REQ-013 SHALL have port mbox_rdy  input  1  consumer pop; pop occurs when mbox_vld & mbox_rdy.
REQ-014 SHALL have port mbox_data  output  32  FIFO head word.

Function
REQ-015 SHALL keep dmem_req_ack tied to 1; a request is accepted in every cycle with dmem_req=1.
REQ-016 SHALL register the response: a request accepted in cycle N gets dmem_resp and dmem_rdata in cycle N+1 only.
REQ-017 SHALL drive dmem_resp=NOTRDY and dmem_rdata=0 in any cycle not following an accepted request.
REQ-018 SHALL support back-to-back requests, one response per cycle, with no bubble.
REQ-019 SHALL decode dmem_addr[3:2]: 0=DATA, 1=STATUS, 2=CTRL, 3=reserved.
REQ-020 SHALL return RDY_ER, with no side effect, for: dmem_addr[1:0]!=0, dmem_width!=WORD, reserved offset, a read of DATA, or a read of CTRL.
REQ-021 SHALL push dmem_wdata into the FIFO on a write to DATA accepted while not full, and respond RDY_OK.
REQ-022 SHALL reject a write to DATA while full (full evaluated on the pre-edge count), respond RDY_ER, and set sticky OVF.
REQ-023 SHALL return STATUS on a read as {16'b0, count[7:0], 5'b0, OVF, full, empty}, sampled at the accept edge, and respond RDY_OK.
REQ-024 SHALL handle a CTRL write as follows: bit0=1 flushes the FIFO (count to 0, pointers to 0); bit1=1 clears OVF; response RDY_OK; other bits ignored.
REQ-025 SHALL drive dmem_rdata=0 on all write responses and on all RDY_ER responses.
REQ-026 SHALL pop the head on mbox_vld & mbox_rdy; mbox_data SHALL be the oldest entry and is don't-care while mbox_vld=0.
REQ-027 SHALL on a simultaneous push and pop when not full: keep count unchanged and preserve order.
REQ-028 SHALL on a simultaneous push and pop when full: reject the push per REQ-022, and the pop still occurs.
REQ-029 SHALL on a flush coinciding with a pop: apply the flush; count is 0 the next cycle.
REQ-030 SHALL give flush priority over a pop in the same cycle; a push is never concurrent with a flush because there is a single request port.
REQ-031 SHALL wrap read/write pointers modulo DEPTH and keep a count of width $clog2(DEPTH)+1, range 0..DEPTH.
REQ-032 SHALL make a push visible on mbox_vld and in STATUS from the cycle after the accept edge.

Reset
REQ-033 SHALL on rst_n=0 force, asynchronously: count=0, pointers=0, OVF=0, mbox_vld=0, dmem_resp=NOTRDY, dmem_rdata=0.
REQ-034 SHALL discard any pending response when reset is asserted mid-transaction; the first response after reset deassertion is for a request accepted after it.
REQ-035 SHALL not reset the FIFO storage array; its contents are unobservable while empty.

Verification
REQ-036 SHALL cover: write DATA 0xA5A5_0001 with mbox_rdy=0 -> next cycle resp RDY_OK; mbox_vld=1, mbox_data=0xA5A5_0001; STATUS read returns 0x0000_0100.
REQ-037 SHALL cover: DEPTH=8, 9 back-to-back DATA writes with mbox_rdy=0 -> 8 RDY_OK then 1 RDY_ER; STATUS=0x0000_0806; CTRL write 0x2 -> STATUS=0x0000_0802.
REQ-038 SHALL cover: FIFO full and mbox_rdy=1 in the same cycle as a DATA write -> RDY_ER, OVF set, count 7 next cycle.
REQ-039 SHALL cover: byte write to DATA, addr 0x2, a read of DATA, and offset 0xC -> each RDY_ER, rdata=0, count unchanged.
REQ-040 SHALL cover: 3 entries queued, CTRL write 0x1 with mbox_rdy=1 -> next cycle mbox_vld=0, STATUS=0x0000_0001.
REQ-041 SHALL cover: rst_n pulsed low between accept and response -> resp NOTRDY, count 0, OVF 0 after release.

Source files
------------

// File: rtl/scr1_dmem_mbox.sv
// scr1_dmem_mbox: data-memory mapped mailbox.
// A core-side dmem slave fronting a word FIFO that a consumer drains
// through a valid/ready port. Three word registers live at offsets
// 0x0 (DATA, write-only push), 0x4 (STATUS, read-only) and 0x8 (CTRL,
// write-only flush / overflow clear). Responses are registered and
// follow the accepting edge by exactly one cycle.
module scr1_dmem_mbox #(
  parameter int DEPTH            = 8,
  parameter int SCR1_DMEM_AWIDTH = 32,
  parameter int SCR1_DMEM_DWIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        dmem_req_ack,
  input  logic                        dmem_req,
  input  logic                        dmem_cmd,
  input  logic [1:0]                  dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
  output logic [1:0]                  dmem_resp,
  output logic                        mbox_vld,
  input  logic                        mbox_rdy,
  output logic [31:0]                 mbox_data
);

  // Pointer and occupancy widths; count must be able to hold DEPTH itself
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic       CMD_WR      = 1'b1;
  localparam logic [1:0] WIDTH_WORD  = 2'd2;
  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_OK     = 2'd1;
  localparam logic [1:0] RESP_ER     = 2'd2;

  localparam logic [1:0] OFF_DATA    = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CTRL    = 2'd2;

  // FIFO storage; deliberately not reset, contents only visible when non-empty
  logic [31:0] mem [DEPTH];

  logic [PW-1:0] wptr_reg, wptr_next;
  logic [PW-1:0] rptr_reg, rptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic [1:0]    resp_reg, resp_next;
  logic [31:0]   rdata_reg, rdata_next;

  logic        full;
  logic        empty;
  logic        fmt_ok;
  logic        is_wr;
  logic [1:0]  offset;
  logic        err;
  logic        push;
  logic        pop;
  logic        flush;
  logic        ovf_set;
  logic        ovf_clr;
  logic        status_rd;
  logic [31:0] status_word;
  logic        unused_addr;

  assign dmem_req_ack = 1'b1;

  assign full   = (count_reg == CW'(DEPTH));
  assign empty  = (count_reg == '0);
  assign offset = dmem_addr[3:2];
  assign is_wr  = (dmem_cmd == CMD_WR);
  assign fmt_ok = (dmem_addr[1:0] == 2'b00) && (dmem_width == WIDTH_WORD);
  assign pop    = mbox_vld & mbox_rdy;

  // Only the low nibble of the address is decoded
  assign unused_addr = ^dmem_addr[SCR1_DMEM_AWIDTH-1:4];

  assign status_word = {16'b0, 8'(count_reg), 5'b0, ovf_reg, full, empty};

  assign mbox_vld   = ~empty;
  assign mbox_data  = mem[rptr_reg];
  assign dmem_resp  = resp_reg;
  assign dmem_rdata = SCR1_DMEM_DWIDTH'(rdata_reg);

  // Request decode: classify the access and derive its side effects
  always_comb begin
    err       = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    ovf_set   = 1'b0;
    ovf_clr   = 1'b0;
    status_rd = 1'b0;
    if (dmem_req) begin
      if (!fmt_ok) begin
        err = 1'b1;
      end else begin
        case (offset)
          OFF_DATA: begin
            if (!is_wr) begin
              err = 1'b1;
            end else if (full) begin
              // Push against a full FIFO is dropped and remembered in OVF
              err     = 1'b1;
              ovf_set = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
          OFF_STATUS: begin
            // Writes to STATUS are accepted and have no effect
            status_rd = ~is_wr;
          end
          OFF_CTRL: begin
            if (!is_wr) begin
              err = 1'b1;
            end else begin
              flush   = dmem_wdata[0];
              ovf_clr = dmem_wdata[1];
            end
          end
          default: err = 1'b1;
        endcase
      end
    end
  end

  // Next FIFO/OVF/response state; flush overrides a concurrent pop
  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    if (flush) begin
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
    end else begin
      if (push) begin
        wptr_next = wptr_reg + PW'(1);
      end
      if (pop) begin
        rptr_next = rptr_reg + PW'(1);
      end
      count_next = count_reg + CW'(push) - CW'(pop);
    end
    if (ovf_set) begin
      ovf_next = 1'b1;
    end else if (ovf_clr) begin
      ovf_next = 1'b0;
    end
    if (!dmem_req) begin
      resp_next = RESP_NOTRDY;
    end else if (err) begin
      resp_next = RESP_ER;
    end else begin
      resp_next = RESP_OK;
    end
    rdata_next = status_rd ? status_word : 32'h0;
  end

  // Control state and registered response, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      resp_reg  <= RESP_NOTRDY;
      rdata_reg <= 32'h0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      resp_reg  <= resp_next;
      rdata_reg <= rdata_next;
    end
  end

  // Storage write on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_reg] <= dmem_wdata[31:0];
    end
  end

endmodule

// File: tb/tb_scr1_dmem_mbox.sv
// tb_scr1_dmem_mbox: table-driven checks of the dmem mailbox with a
// response scoreboard and a reference model of the FIFO contents.
module tb_scr1_dmem_mbox;

  localparam logic       RD = 1'b0;
  localparam logic       WR = 1'b1;
  localparam logic [1:0] WB = 2'd0;
  localparam logic [1:0] WW = 2'd2;
  localparam logic [1:0] NR = 2'd0;
  localparam logic [1:0] OK = 2'd1;
  localparam logic [1:0] ER = 2'd2;
  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_CTRL = 32'h8;
  localparam logic [31:0] A_RSVD = 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmem_req_ack;
  logic        dmem_req = 1'b0;
  logic        dmem_cmd = 1'b0;
  logic [1:0]  dmem_width = 2'd0;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_wdata = 32'h0;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;
  logic        mbox_vld;
  logic        mbox_rdy = 1'b0;
  logic [31:0] mbox_data;

  scr1_dmem_mbox #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_req_ack (dmem_req_ack),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .mbox_vld     (mbox_vld),
    .mbox_rdy     (mbox_rdy),
    .mbox_data    (mbox_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        cmd;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] mq[$];
  int          checks = 0;
  int          errors = 0;
  int          txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic req, input logic cmd, input logic [1:0] width,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic rdy, input logic [1:0] er, input logic [31:0] ed);
    vec_t v;
    v.req = req; v.cmd = cmd; v.width = width; v.addr = addr; v.wdata = wdata;
    v.rdy = rdy; v.exp_resp = er; v.exp_rdata = ed;
    return v;
  endfunction

  // Checks the previous cycle's response and the current mailbox head,
  // then drives one transaction for the next accept edge.
  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("resp", 32'(dmem_resp), 32'(e.resp));
      check("rdata", dmem_rdata, e.rdata);
    end else begin
      check("idle_resp", 32'(dmem_resp), 32'(NR));
      check("idle_rdata", dmem_rdata, 32'h0);
    end
    check("mbox_vld", 32'(mbox_vld), 32'(mq.size() > 0));
    if (mq.size() > 0) check("mbox_data", mbox_data, mq[0]);
    check("req_ack", 32'(dmem_req_ack), 32'h1);

    dmem_req   = v.req;
    dmem_cmd   = v.cmd;
    dmem_width = v.width;
    dmem_addr  = v.addr;
    dmem_wdata = v.wdata;
    mbox_rdy   = v.rdy;
    if (v.req) begin
      e.resp  = v.exp_resp;
      e.rdata = v.exp_rdata;
      sb.push_back(e);
    end
    txn++;
    $display("txn %0d: req=%0b cmd=%0b width=%0d addr=0x%0h wdata=0x%08h rdy=%0b exp_resp=%0d exp_rdata=0x%08h",
             txn, v.req, v.cmd, v.width, v.addr, v.wdata, v.rdy, v.exp_resp, v.exp_rdata);

    // Model the FIFO effect of the upcoming edge
    if (v.req && v.cmd == WR && v.addr == A_CTRL && v.width == WW && v.wdata[0]) begin
      mq.delete();
    end else begin
      if (v.rdy && mq.size() > 0) void'(mq.pop_front());
      if (v.req && v.cmd == WR && v.addr == A_DATA && v.exp_resp == OK) mq.push_back(v.wdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single write, then flush and confirm empty STATUS
    vecs.push_back(mk(1, WR, WW, A_DATA, 32'hA5A5_0001, 0, OK, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_STAT, 32'h0, 0, OK, 32'h0000_0100));
    vecs.push_back(mk(0, RD, WW, A_DATA, 32'h0, 0, NR, 32'h0));
    vecs.push_back(mk(1, WR, WW, A_CTRL, 32'h1, 0, OK, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_STAT, 32'h0, 0, OK, 32'h0000_0001));
    // Overfill by one, then clear OVF
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(1, WR, WW, A_DATA, 32'h1000 + i, 0, (i < 8) ? OK : ER, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_STAT, 32'h0, 0, OK, 32'h0000_0806));
    vecs.push_back(mk(1, WR, WW, A_CTRL, 32'h2, 0, OK, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_STAT, 32'h0, 0, OK, 32'h0000_0802));
    // Malformed or illegal accesses: no side effect
    vecs.push_back(mk(1, WR, WB, A_DATA, 32'hFF, 0, ER, 32'h0));
    vecs.push_back(mk(1, WR, WW, 32'h2, 32'h77, 0, ER, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_DATA, 32'h0, 0, ER, 32'h0));
    vecs.push_back(mk(1, WR, WW, A_RSVD, 32'h3, 0, ER, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_RSVD, 32'h0, 0, ER, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_CTRL, 32'h0, 0, ER, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_STAT, 32'h0, 0, OK, 32'h0000_0802));
    // Full with a concurrent pop: push rejected, pop still happens
    vecs.push_back(mk(1, WR, WW, A_DATA, 32'hDEAD_0000, 1, ER, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_STAT, 32'h0, 0, OK, 32'h0000_0704));
    // Not full with a concurrent pop: count unchanged
    vecs.push_back(mk(1, WR, WW, A_DATA, 32'hBEEF_0001, 1, OK, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_STAT, 32'h0, 0, OK, 32'h0000_0704));
    vecs.push_back(mk(1, WR, WW, A_STAT, 32'h5, 0, OK, 32'h0));
    vecs.push_back(mk(1, WR, WW, A_CTRL, 32'h3, 0, OK, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_STAT, 32'h0, 0, OK, 32'h0000_0001));
    // Three queued, then flush coinciding with a pop
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, WR, WW, A_DATA, 32'h2000 + i, 0, OK, 32'h0));
    vecs.push_back(mk(1, WR, WW, A_CTRL, 32'h1, 1, OK, 32'h0));
    vecs.push_back(mk(1, RD, WW, A_STAT, 32'h0, 0, OK, 32'h0000_0001));
    // Refill to full with OVF set ahead of the reset sequence
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(1, WR, WW, A_DATA, 32'h3000 + i, 0, (i < 8) ? OK : ER, 32'h0));

    // Reset state
    repeat (2) begin
      @(negedge clk);
      check("rst_resp", 32'(dmem_resp), 32'(NR));
      check("rst_rdata", dmem_rdata, 32'h0);
      check("rst_vld", 32'(mbox_vld), 32'h0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

    // Reset pulse between accept and response
    drive(mk(1, RD, WW, A_STAT, 32'h0, 0, OK, 32'h0000_0806));
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    dmem_req = 1'b0;
    mbox_rdy = 1'b0;
    #1;
    check("midrst_resp", 32'(dmem_resp), 32'(NR));
    check("midrst_rdata", dmem_rdata, 32'h0);
    check("midrst_vld", 32'(mbox_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn %0d: reset pulsed with a response pending", ++txn);
    sb.delete();
    mq.delete();
    drive(mk(1, RD, WW, A_STAT, 32'h0, 0, OK, 32'h0000_0001));
    drive(mk(0, RD, WW, A_DATA, 32'h0, 0, NR, 32'h0));
    drive(mk(0, RD, WW, A_DATA, 32'h0, 0, NR, 32'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
